// File: rtl/acc_27_pkg.sv
// rtl/acc_27_pkg.sv - shared types, widths, cfg field slices and rounding helper for acc_27
package hevc_acc_pkg;

  localparam int PROD_W = 27;
  localparam int ACC_W  = 32;
  localparam int RES_W  = 16;

  localparam int TAPS_MSB  = 7;
  localparam int TAPS_LSB  = 4;
  localparam int SHIFT_MSB = 3;
  localparam int SHIFT_LSB = 0;

  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((2 ** (RES_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] RES_MIN = -ACC_W'(2 ** (RES_W - 1));

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Round half up, then arithmetic shift right; shift of 0 passes the sum through.
  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] sum,
    input logic [3:0]              shift
  );
    logic signed [ACC_W-1:0] rnd;
    rnd = (shift == 4'd0) ? '0 : (ACC_W'(1) << (shift - 4'd1));
    return (sum + rnd) >>> shift;
  endfunction

endpackage

// File: rtl/acc_27_if.sv
// rtl/acc_27_if.sv - first-word-fall-through multi-flux FIFO read and write interfaces
interface read_interface #(
  parameter int DW = 28,
  parameter int N  = 2
);
  logic [DW-1:0] dout;
  logic [N-1:0]  empty;
  logic [N-1:0]  read;

  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
  parameter int DW = 17,
  parameter int N  = 2
);
  logic [DW-1:0] din;
  logic [N-1:0]  full;
  logic [N-1:0]  write;

  modport actor (output din, output write, input full);
  modport fifo  (input din, input write, output full);
endinterface

// File: rtl/acc_27_arb.sv
// rtl/acc_27_arb.sv - combinational lowest-index eligible-flux picker
module acc_27_arb #(
  parameter int  FLUX  = 2,
  localparam int TAG_W = $clog2(FLUX)
) (
  input  logic [FLUX-1:0]  in_accum,
  input  logic [FLUX-1:0]  last,
  input  logic [FLUX-1:0]  cfg_empty,
  input  logic [FLUX-1:0]  prod_empty,
  input  logic [FLUX-1:0]  res_full,
  output logic [TAG_W-1:0] sel_tag,
  output logic             sel_valid
);

  // Scan from the top down so the lowest eligible index is the one that sticks.
  always_comb begin
    sel_tag   = '0;
    sel_valid = 1'b0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if ((!in_accum[i] && !cfg_empty[i]) ||
          (in_accum[i] && !prod_empty[i] && (!last[i] || !res_full[i]))) begin
        sel_tag   = TAG_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_27.sv
// rtl/acc_27.sv - multi-flux NUM_TAPS accumulator with round/shift; ACC_27_SAT_EN enables output saturation
module acc_27
  import hevc_acc_pkg::*;
#(
  parameter int  FLUX  = 2,
  localparam int TAG_W = $clog2(FLUX)
) (
  input  logic          clk,
  input  logic          rst,
  read_interface.actor  read_port_prod,
  read_interface.actor  read_port_cfg,
  write_interface.actor write_port_res
);

  state_e                  state_q [FLUX];
  state_e                  state_d [FLUX];
  logic signed [ACC_W-1:0] acc_q   [FLUX];
  logic signed [ACC_W-1:0] acc_d   [FLUX];
  logic [3:0]              cnt_q   [FLUX];
  logic [3:0]              cnt_d   [FLUX];
  logic [4:0]              taps_q  [FLUX];
  logic [4:0]              taps_d  [FLUX];
  logic [3:0]              shift_q [FLUX];
  logic [3:0]              shift_d [FLUX];

  logic [FLUX-1:0]  in_accum;
  logic [FLUX-1:0]  last;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_valid;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  r;
  logic [RES_W-1:0]         res;
  logic [3:0]               cfg_taps;
  logic                     unused_tags;

  // Input tag bits carry no meaning here; the served flux index is the tag.
  assign unused_tags = ^{read_port_prod.dout[PROD_W+TAG_W-1:PROD_W],
                         read_port_cfg.dout[8+TAG_W-1:8]};
  assign prod        = read_port_prod.dout[PROD_W-1:0];
  assign cfg_taps    = read_port_cfg.dout[TAPS_MSB:TAPS_LSB];

  // Per-flux status flags feeding the arbiter.
  always_comb begin
    in_accum = '0;
    last     = '0;
    for (int i = 0; i < FLUX; i++) begin
      in_accum[i] = (state_q[i] == ACCUM);
      last[i]     = ({1'b0, cnt_q[i]} == (taps_q[i] - 5'd1));
    end
  end

  acc_27_arb #(.FLUX(FLUX)) u_arb (
    .in_accum   (in_accum),
    .last       (last),
    .cfg_empty  (read_port_cfg.empty),
    .prod_empty (read_port_prod.empty),
    .res_full   (write_port_res.full),
    .sel_tag    (sel_tag),
    .sel_valid  (sel_valid)
  );

  // Datapath for the selected flux: sum, round/shift and optional clamp to RES_W.
  always_comb begin
    sum = acc_q[sel_tag] + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    r   = round_shift(sum, shift_q[sel_tag]);
`ifdef ACC_27_SAT_EN
    if (r > RES_MAX) begin
      res = RES_MAX[RES_W-1:0];
    end else if (r < RES_MIN) begin
      res = RES_MIN[RES_W-1:0];
    end else begin
      res = r[RES_W-1:0];
    end
`else
    res = r[RES_W-1:0];
`endif
  end

  // Next-state and FIFO strobes; only the arbitrated flux moves, others hold.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    taps_d  = taps_q;
    shift_d = shift_q;
    read_port_prod.read  = '0;
    read_port_cfg.read   = '0;
    write_port_res.write = '0;
    write_port_res.din   = '0;
    if (!rst && sel_valid) begin
      if (state_q[sel_tag] == IDLE) begin
        read_port_cfg.read[sel_tag] = 1'b1;
        taps_d[sel_tag]  = (cfg_taps == 4'd0) ? 5'd16 : {1'b0, cfg_taps};
        shift_d[sel_tag] = read_port_cfg.dout[SHIFT_MSB:SHIFT_LSB];
        acc_d[sel_tag]   = '0;
        cnt_d[sel_tag]   = '0;
        state_d[sel_tag] = ACCUM;
      end else if (last[sel_tag]) begin
        read_port_prod.read[sel_tag]  = 1'b1;
        write_port_res.write[sel_tag] = 1'b1;
        write_port_res.din            = {sel_tag, res};
        acc_d[sel_tag]   = '0;
        cnt_d[sel_tag]   = '0;
        state_d[sel_tag] = IDLE;
      end else begin
        read_port_prod.read[sel_tag] = 1'b1;
        acc_d[sel_tag] = sum;
        cnt_d[sel_tag] = cnt_q[sel_tag] + 4'd1;
      end
    end
  end

  // Context registers; reset drops every partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        state_q[i] <= IDLE;
        acc_q[i]   <= '0;
        cnt_q[i]   <= '0;
        taps_q[i]  <= '0;
        shift_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_acc_27.sv
// tb/tb_acc_27.sv - directed self-checking bench for acc_27 (honours ACC_27_SAT_EN)
module tb_acc_27;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int n_tests = 0;
  int n_fail  = 0;

  int prod_mem [2][128];
  int cfg_mem  [2][32];
  int prod_wr  [2] = '{0, 0};
  int prod_rd  [2] = '{0, 0};
  int cfg_wr   [2] = '{0, 0};
  int cfg_rd   [2] = '{0, 0};

  logic psel;
  logic csel;

  read_interface  #(.DW(28), .N(2)) prod_if ();
  read_interface  #(.DW(9),  .N(2)) cfg_if ();
  write_interface #(.DW(17), .N(2)) res_if ();

  acc_27 #(.FLUX(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .read_port_prod (prod_if),
    .read_port_cfg  (cfg_if),
    .write_port_res (res_if)
  );

  always #5 clk = ~clk;

  assign prod_if.empty = {prod_rd[1] == prod_wr[1], prod_rd[0] == prod_wr[0]};
  assign cfg_if.empty  = {cfg_rd[1] == cfg_wr[1], cfg_rd[0] == cfg_wr[0]};
  assign psel          = prod_if.read[1];
  assign csel          = cfg_if.read[1];
  assign prod_if.dout  = {1'b1, prod_mem[psel][prod_rd[psel]][26:0]};
  assign cfg_if.dout   = {1'b1, cfg_mem[csel][cfg_rd[csel]][7:0]};

  always @(posedge clk) begin
    for (int f = 0; f < 2; f++) begin
      if (flush) begin
        prod_rd[f] <= prod_wr[f];
        cfg_rd[f]  <= cfg_wr[f];
      end else begin
        if (prod_if.read[f]) prod_rd[f] <= prod_rd[f] + 1;
        if (cfg_if.read[f])  cfg_rd[f]  <= cfg_rd[f] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_cfg(input int f, input int taps, input int shift);
    cfg_mem[f][cfg_wr[f]] = (taps << 4) | shift;
    cfg_wr[f] = cfg_wr[f] + 1;
  endtask

  task automatic push_prod(input int f, input int v);
    prod_mem[f][prod_wr[f]] = v;
    prod_wr[f] = prod_wr[f] + 1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [16:0] exp);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (res_if.write != 2'b00) begin
        seen = 1'b1;
        check_eq({tag, "_din"}, 32'(res_if.din), 32'(exp));
        check_eq({tag, "_wr"}, 32'(res_if.write), exp[16] ? 32'd2 : 32'd1);
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    res_if.full = 2'b00;

    // reset: pending cfg and product must not be read while rst is high
    @(negedge clk);
    push_cfg(0, 1, 0);
    push_prod(0, 1);
    #1;
    check_eq("rst_cfg_rd", 32'(cfg_if.read), 32'd0);
    check_eq("rst_prod_rd", 32'(prod_if.read), 32'd0);
    check_eq("rst_wr", 32'(res_if.write), 32'd0);
    do_flush();
    rst = 1'b0;
    @(negedge clk);
    push_prod(0, 5);
    #1;
    check_eq("rst_idle_prod", 32'(prod_if.read), 32'd0);
    do_flush();

    // 1: basic sum 4x64, shift 6 -> 4
    @(negedge clk);
    push_cfg(0, 4, 6);
    for (int k = 0; k < 4; k++) push_prod(0, 64);
    wait_res("basic", 17'h00004);
    @(negedge clk);
    push_prod(0, 9);
    #1;
    check_eq("basic_idle", 32'(prod_if.read), 32'd0);
    do_flush();

    // 2: negative rounding -200 >>> 3 with rounding -> -25
    @(negedge clk);
    push_cfg(0, 2, 3);
    push_prod(0, -100);
    push_prod(0, -100);
    wait_res("neg", 17'h0FFE7);

    // 3: 2^25 + 2^25 = 2^26 exceeds 16 bits
    @(negedge clk);
    push_cfg(0, 2, 0);
    push_prod(0, 1 << 25);
    push_prod(0, 1 << 25);
`ifdef ACC_27_SAT_EN
    wait_res("sat", 17'h07FFF);
`else
    wait_res("sat", 17'h00000);
`endif

    // 4: backpressure on the last product
    @(negedge clk);
    res_if.full = 2'b01;
    push_cfg(0, 2, 0);
    push_prod(0, 5);
    push_prod(0, 7);
    repeat (5) @(negedge clk);
    #1;
    check_eq("bp_no_wr", 32'(res_if.write), 32'd0);
    check_eq("bp_no_rd", 32'(prod_if.read), 32'd0);
    check_eq("bp_held", 32'(prod_wr[0] - prod_rd[0]), 32'd1);
    res_if.full = 2'b00;
    #1;
    check_eq("bp_release_wr", 32'(res_if.write), 32'd1);
    check_eq("bp_release_din", 32'(res_if.din), 32'h0000C);
    check_eq("bp_release_rd", 32'(prod_if.read), 32'd1);

    // 5: two fluxes, flux0 first, independent sums
    @(negedge clk);
    push_cfg(0, 2, 0);
    push_cfg(1, 3, 0);
    push_prod(0, 10);
    push_prod(0, 10);
    for (int k = 0; k < 3; k++) push_prod(1, 7);
    #1;
    check_eq("two_first_cfg", 32'(cfg_if.read), 32'd1);
    wait_res("two_f0", 17'h00014);
    wait_res("two_f1", 17'h10015);

    // 6: reset after 2 of 4 products, then a clean run
    @(negedge clk);
    push_cfg(0, 4, 0);
    for (int k = 0; k < 4; k++) push_prod(0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_consumed", 32'(prod_wr[0] - prod_rd[0]), 32'd2);
    check_eq("mid_rst_prod_rd", 32'(prod_if.read), 32'd0);
    check_eq("mid_rst_cfg_rd", 32'(cfg_if.read), 32'd0);
    check_eq("mid_rst_wr", 32'(res_if.write), 32'd0);
    do_flush();
    rst = 1'b0;
    @(negedge clk);
    push_cfg(0, 4, 0);
    for (int k = 0; k < 4; k++) push_prod(0, 1);
    wait_res("after_rst", 17'h00004);

    // taps field 0 means 16 taps: 16x3 = 48, shift 4 -> 3
    @(negedge clk);
    push_cfg(0, 0, 4);
    for (int k = 0; k < 16; k++) push_prod(0, 3);
    wait_res("taps16", 17'h00003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
